controle_temporizador: RTL and testbench
========================================

Name: controle_temporizador

Overview:
Scheduler that shares one prescaled timing resource (ripple-style divide-by-2^k tick plus delay down-counter) among NREQ requesters, e.g. processor state machines needing wait intervals. Round-robin arbitration grants one requester at a time. The block counts that requester's programmed delay in prescaled ticks and returns a one-cycle completion pulse. Sits between control FSMs and the shared timer.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 16, delay counter width in ticks
PW, 8, prescaler width; tap_sel range 0..PW-1

Ports:
clkf  in  1  system clock, rising edge
rstf_n  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester; held until fim or cancel
atraso  in  NREQ*CW  delay per requester in ticks, slice i = atraso[i*CW +: CW]
tap_sel  in  3  prescaler tap; tick period P = 2^(tap_sel+1) cycles
gnt  out  NREQ  one-hot grant, high while the requester's delay is counting
fim  out  NREQ  one-cycle done pulse to the granted requester
ocupado  out  1  high whenever state != OCIOSO
tick  out  1  prescaled tick (debug/observe), valid only in CONTA

Behaviour:
- One clock (clkf); reset asynchronous, active-low (rstf_n). All state and outputs are registered.
- Reset values: state=OCIOSO, gnt=0, fim=0, ocupado=0, tick=0, prescaler=0, cnt=0, rr pointer=0 (requester 0 has highest priority first).
- FSM states: OCIOSO, CONTA, FIM.
- OCIOSO: if any req bit is high, select the first set bit searching from rr_ptr upward with wrap. Latch idx, cnt=atraso[idx], and tap_sel (clamped to PW-1). Clear the prescaler. If the latched delay is nonzero, go to CONTA and set gnt[idx] in the same edge. If it is zero, go straight to FIM with gnt staying 0.
- Latency: req sampled high at edge E gives gnt high from cycle E+1.
- CONTA: the prescaler increments every cycle. tick=1 when prescaler[tap:0] is all ones. On each tick cnt decrements. A tick with cnt==1 moves to FIM. With grant at cycle G, fim is high exactly at cycle G + D*P. gnt is high for cycles G .. G+D*P-1.
- FIM: fim[idx]=1 for exactly one cycle, gnt=0, rr_ptr=idx+1 mod NREQ. Then go to OCIOSO. No back-to-back grant: at least one OCIOSO cycle separates grants.
- Cancel: req[idx] low during CONTA aborts on the next edge. The block goes to OCIOSO, gnt cleared, no fim, rr_ptr=idx+1.
- The latched atraso and tap_sel are frozen during a grant. Input changes take effect at the next grant only.
- req[idx] still high in the cycle after fim is treated as a new request. It is arbitrated behind the other requesters by rr_ptr.
- Simultaneous requests: exactly one is granted. Others wait with no loss; requests are level, so nothing is queued internally.
- A tick with cnt>1 in the same cycle as a req drop: the cancel wins and no fim is issued.
- tap_sel values above PW-1 are clamped to PW-1.
- Reset mid-operation: immediate return to reset values; gnt and fim are cleared asynchronously.
- Widths: cnt is CW bits and never wraps. Decrement occurs only when cnt>=1.

Decomposition:
- Shared package: state encoding constants (OCIOSO=2'd0, CONTA=2'd1, FIM=2'd2), NREQ/CW/PW defaults, and the tap clamp width.
- One sub-module, prescaler_tick: PW-bit counter with sync clear and tap select, producing tick.
- Round-robin selection and the FSM stay in the top module.

Test Plan:
- Reset held with req=4'b1111 -> gnt=0, fim=0, ocupado=0. After release, gnt=4'b0001 one cycle after the first sampling edge.
- Single request, req[2]=1, atraso[2]=3, tap_sel=0 (P=2) -> gnt[2] high 6 cycles; fim[2] pulse at G+6; ocupado low one cycle later.
- req=4'b1011 held, all atraso=1, tap_sel=0 -> grant order 0,1,3,0, each fim separated by one idle cycle.
- Cancel: req[1], atraso=10, tap_sel=2 (P=8); drop req[1] at G+20 -> gnt clears at G+21, no fim, next grant searches from requester 2.
- atraso[0]=0 -> no gnt; fim[0] one cycle after the request is sampled. tap_sel=7 with PW=4 -> period clamped to P=16.
- Change atraso and tap_sel mid-count -> fim timing unchanged. Assert rstf_n low mid-CONTA -> gnt drops asynchronously; no fim after release.

Source files
------------

// File: rtl/controle_temporizador_pkg.sv
// controle_temporizador_pkg: shared types and defaults for the shared-timer scheduler.
// Contents: FSM state encoding, default NREQ/CW/PW, width of the tap_sel input
// that gets clamped to PW-1 inside the top.
package controle_temporizador_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CONTA  = 2'd1,
    FIM    = 2'd2
  } estado_t;

  localparam int NREQ_DEF  = 4;
  localparam int CW_DEF    = 16;
  localparam int PW_DEF    = 8;
  // tap_sel is always 3 bits wide; values above PW-1 are clamped in the top.
  localparam int TAP_SEL_W = 3;

endpackage

// File: rtl/controle_temporizador_prescaler_tick.sv
// prescaler_tick: PW-bit free-running prescaler with synchronous clear and tap select.
// Ports: clkf/rstf_n clock and async reset; clr holds the count at zero; tap picks
// bit range [tap:0]; tick is high (registered) while the count has those bits all ones.
module prescaler_tick #(
  parameter int PW = 8,
  parameter int TW = 3
) (
  input  logic          clkf,
  input  logic          rstf_n,
  input  logic          clr,
  input  logic [TW-1:0] tap,
  output logic          tick
);

  logic [PW-1:0] pre_q, pre_d;
  logic [PW-1:0] mask;
  logic [PW:0]   span;
  logic          tick_q;

  // mask = 2^(tap+1)-1; computed one bit wider so tap=PW-1 gives all ones.
  always_comb begin
    span  = (PW+1)'(1) << (int'(tap) + 1);
    mask  = PW'(span - (PW+1)'(1));
    pre_d = clr ? '0 : pre_q + PW'(1);
  end

  // tick is registered from the next count so it lines up with pre_q.
  always_ff @(posedge clkf or negedge rstf_n) begin
    if (!rstf_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= &(pre_d | ~mask);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/controle_temporizador.sv
// controle_temporizador: round-robin scheduler sharing one prescaled delay timer among NREQ requesters.
// Ports: req/atraso/tap_sel per-request level inputs; gnt one-hot while counting, fim one-cycle done,
// ocupado busy flag, tick prescaled tick observe. Grant one cycle after req is sampled; fim at G+D*P.
module controle_temporizador
  import controle_temporizador_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF,
  parameter int PW   = PW_DEF
) (
  input  logic                 clkf,
  input  logic                 rstf_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   atraso,
  input  logic [TAP_SEL_W-1:0] tap_sel,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      fim,
  output logic                 ocupado,
  output logic                 tick
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (PW > 1) ? $clog2(PW) : 1;

  estado_t         state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] fim_q, fim_d;
  logic            ocupado_q;

  logic            sel_vld;
  logic [IW-1:0]   sel_idx;
  logic [TW-1:0]   tap_clamp;
  logic [IW-1:0]   idx_next;
  logic            pre_clr;
  logic            tick_int;

  // Round-robin: first set req bit starting at rr_q, wrapping past NREQ-1.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      automatic int j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!sel_vld && req[j]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(j);
      end
    end
  end

  always_comb begin
    tap_clamp = (int'(tap_sel) > PW - 1) ? TW'(PW - 1) : TW'(tap_sel);
    idx_next  = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + IW'(1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    gnt_d   = gnt_q;
    fim_d   = '0;
    unique case (state_q)
      OCIOSO: begin
        if (sel_vld) begin
          idx_d = sel_idx;
          cnt_d = atraso[int'(sel_idx)*CW +: CW];
          tap_d = tap_clamp;
          if (cnt_d != '0) begin
            state_d = CONTA;
            gnt_d   = NREQ'(1) << sel_idx;
          end else begin
            // Zero delay: report completion immediately without ever granting.
            state_d = FIM;
            fim_d   = NREQ'(1) << sel_idx;
          end
        end
      end
      CONTA: begin
        // A dropped request wins over any tick in the same cycle.
        if (!req[idx_q]) begin
          state_d = OCIOSO;
          gnt_d   = '0;
          rr_d    = idx_next;
        end else if (tick_int && cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FIM;
            gnt_d   = '0;
            fim_d   = NREQ'(1) << idx_q;
          end
        end
      end
      FIM: begin
        state_d = OCIOSO;
        rr_d    = idx_next;
      end
      default: begin
        state_d = OCIOSO;
        gnt_d   = '0;
      end
    endcase
  end

  // The prescaler only runs while staying in CONTA, so it starts from zero at each grant.
  assign pre_clr = !(state_q == CONTA && state_d == CONTA);

  prescaler_tick #(
    .PW (PW),
    .TW (TW)
  ) u_prescaler (
    .clkf   (clkf),
    .rstf_n (rstf_n),
    .clr    (pre_clr),
    .tap    (tap_q),
    .tick   (tick_int)
  );

  always_ff @(posedge clkf or negedge rstf_n) begin
    if (!rstf_n) begin
      state_q   <= OCIOSO;
      idx_q     <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      tap_q     <= '0;
      gnt_q     <= '0;
      fim_q     <= '0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      tap_q     <= tap_d;
      gnt_q     <= gnt_d;
      fim_q     <= fim_d;
      ocupado_q <= (state_d != OCIOSO);
    end
  end

  assign gnt     = gnt_q;
  assign fim     = fim_q;
  assign ocupado = ocupado_q;
  assign tick    = tick_int;

endmodule

// File: tb/tb_controle_temporizador.sv
module tb_controle_temporizador;

  localparam int NREQ = 4;
  localparam int CW   = 16;
  localparam int PW   = 8;

  logic                 clkf = 1'b0;
  logic                 rstf_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*CW-1:0]   atraso;
  logic [2:0]           tap_sel;
  logic [NREQ-1:0]      gnt, fim;
  logic                 ocupado, tick;

  // second instance with a narrow prescaler, used for the tap clamp
  logic [NREQ-1:0]      req4;
  logic [NREQ*CW-1:0]   atraso4;
  logic [2:0]           tap4;
  logic [NREQ-1:0]      gnt4, fim4;
  logic                 ocupado4, tick4;

  int tests = 0;
  int fails = 0;

  always #5 clkf = ~clkf;

  controle_temporizador #(.NREQ(NREQ), .CW(CW), .PW(PW)) dut (
    .clkf(clkf), .rstf_n(rstf_n), .req(req), .atraso(atraso), .tap_sel(tap_sel),
    .gnt(gnt), .fim(fim), .ocupado(ocupado), .tick(tick)
  );

  controle_temporizador #(.NREQ(NREQ), .CW(CW), .PW(4)) dut4 (
    .clkf(clkf), .rstf_n(rstf_n), .req(req4), .atraso(atraso4), .tap_sel(tap4),
    .gnt(gnt4), .fim(fim4), .ocupado(ocupado4), .tick(tick4)
  );

  // ---------------- reference model (cycle counting, not prescaler/tick) -------------
  int m_phase;   // 0 idle, 1 granted, 2 done pulse
  int m_idx, m_rr, m_len, m_el, m_p;

  function automatic void model_edge(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] a,
                                     input logic [2:0] t);
    int d, tc;
    bit found;
    case (m_phase)
      0: begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && r[(m_rr + k) % NREQ]) begin
            found = 1;
            m_idx = (m_rr + k) % NREQ;
          end
        end
        if (found) begin
          d   = int'(a[m_idx*CW +: CW]);
          tc  = (int'(t) > PW - 1) ? PW - 1 : int'(t);
          m_p = 2 ** (tc + 1);
          if (d == 0) m_phase = 2;
          else begin
            m_phase = 1;
            m_len   = d * m_p;
            m_el    = 0;
          end
        end
      end
      1: begin
        if (!r[m_idx]) begin
          m_phase = 0;
          m_rr    = (m_idx + 1) % NREQ;
        end else begin
          m_el++;
          if (m_el == m_len) m_phase = 2;
        end
      end
      default: begin
        m_phase = 0;
        m_rr    = (m_idx + 1) % NREQ;
      end
    endcase
  endfunction

  task automatic cyc();
    @(posedge clkf);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstf_n  = 1'b0;
    req     = 4'b1111;
    atraso  = {4{16'd2}};
    tap_sel = 3'd0;
    req4    = '0;
    atraso4 = '0;
    tap4    = 3'd0;
    repeat (3) cyc();
    tests++;
    if (gnt !== 4'b0000 || fim !== 4'b0000 || ocupado !== 1'b0 || tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: gnt=%b fim=%b ocupado=%b tick=%b, required 0000 0000 0 0",
               gnt, fim, ocupado, tick);
    end
    rstf_n = 1'b1;
    cyc();
    tests++;
    if (gnt !== 4'b0001 || ocupado !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_grant: gnt=%b ocupado=%b, required 0001 1", gnt, ocupado);
    end
    req = '0;
    cyc();
    tests++;
    if (gnt !== 4'b0000 || fim !== 4'b0000) begin
      fails++;
      $display("FAIL reset_cancel: gnt=%b fim=%b, required 0000 0000", gnt, fim);
    end
  endtask

  task automatic test_single();
    int n;
    atraso[2*CW +: CW] = 16'd3;
    tap_sel = 3'd0;
    req     = 4'b0100;
    cyc();
    n = 0;
    while (gnt === 4'b0100 && n < 40) begin
      n++;
      cyc();
    end
    tests++;
    if (n != 6) begin
      fails++;
      $display("FAIL single_gnt_len: %0d cycles, required 6", n);
    end
    tests++;
    if (fim !== 4'b0100) begin
      fails++;
      $display("FAIL single_fim: fim=%b, required 0100", fim);
    end
    req = '0;
    cyc();
    tests++;
    if (ocupado !== 1'b0 || fim !== 4'b0000) begin
      fails++;
      $display("FAIL single_idle: ocupado=%b fim=%b, required 0 0000", ocupado, fim);
    end
  endtask

  task automatic test_round_robin();
    int ord [4] = '{0, 1, 3, 0};
    logic [NREQ-1:0] oh;
    rstf_n  = 1'b0;
    req     = 4'b1011;
    atraso  = {4{16'd1}};
    tap_sel = 3'd0;
    cyc();
    rstf_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      oh = 4'b0001 << ord[g];
      cyc();
      tests++;
      if (gnt !== oh) begin
        fails++;
        $display("FAIL rr_grant%0d: gnt=%b, required %b", g, gnt, oh);
      end
      cyc();
      tests++;
      if (gnt !== oh) begin
        fails++;
        $display("FAIL rr_hold%0d: gnt=%b, required %b", g, gnt, oh);
      end
      cyc();
      tests++;
      if (fim !== oh || gnt !== 4'b0000) begin
        fails++;
        $display("FAIL rr_fim%0d: fim=%b gnt=%b, required %b 0000", g, fim, gnt, oh);
      end
      if (g == 3) req = '0;
      cyc();
      tests++;
      if (gnt !== 4'b0000 || fim !== 4'b0000 || ocupado !== 1'b0) begin
        fails++;
        $display("FAIL rr_idle%0d: gnt=%b fim=%b ocupado=%b, required 0000 0000 0", g, gnt, fim,
                 ocupado);
      end
    end
  endtask

  task automatic test_cancel();
    bit ok;
    atraso[1*CW +: CW] = 16'd10;
    tap_sel = 3'd2;
    req     = 4'b0010;
    cyc();
    ok = (gnt === 4'b0010);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (gnt !== 4'b0010 || fim !== 4'b0000) ok = 0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cancel_hold: gnt=%b fim=%b at G+20, required 0010 0000 throughout", gnt, fim);
    end
    req = '0;
    cyc();
    tests++;
    if (gnt !== 4'b0000 || fim !== 4'b0000 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL cancel_drop: gnt=%b fim=%b ocupado=%b, required 0000 0000 0", gnt, fim, ocupado);
    end
    req = 4'b1011;
    cyc();
    tests++;
    if (gnt !== 4'b1000) begin
      fails++;
      $display("FAIL cancel_next_rr: gnt=%b, required 1000", gnt);
    end
    req = '0;
    cyc();
    tests++;
    if (gnt !== 4'b0000 || fim !== 4'b0000) begin
      fails++;
      $display("FAIL cancel_second: gnt=%b fim=%b, required 0000 0000", gnt, fim);
    end
  endtask

  task automatic test_zero_delay();
    atraso[0 +: CW] = 16'd0;
    req = 4'b0001;
    cyc();
    tests++;
    if (fim !== 4'b0001 || gnt !== 4'b0000 || ocupado !== 1'b1) begin
      fails++;
      $display("FAIL zero_fim: fim=%b gnt=%b ocupado=%b, required 0001 0000 1", fim, gnt, ocupado);
    end
    req = '0;
    cyc();
    tests++;
    if (fim !== 4'b0000 || ocupado !== 1'b0) begin
      fails++;
      $display("FAIL zero_idle: fim=%b ocupado=%b, required 0000 0", fim, ocupado);
    end
  endtask

  task automatic test_clamp();
    int n;
    atraso4[0 +: CW] = 16'd2;
    tap4 = 3'd7;
    req4 = 4'b0001;
    cyc();
    n = 0;
    while (gnt4 === 4'b0001 && n < 60) begin
      n++;
      cyc();
    end
    tests++;
    if (n != 32 || fim4 !== 4'b0001) begin
      fails++;
      $display("FAIL clamp_period: gnt cycles=%0d fim=%b, required 32 0001", n, fim4);
    end
    req4 = '0;
    cyc();
  endtask

  task automatic test_freeze();
    int n;
    atraso[2*CW +: CW] = 16'd2;
    tap_sel = 3'd1;
    req     = 4'b0100;
    cyc();
    n = 0;
    while (gnt === 4'b0100 && n < 40) begin
      n++;
      if (n == 3) begin
        atraso[2*CW +: CW] = 16'd50;
        tap_sel = 3'd5;
      end
      cyc();
    end
    tests++;
    if (n != 8 || fim !== 4'b0100) begin
      fails++;
      $display("FAIL freeze_timing: gnt cycles=%0d fim=%b, required 8 0100", n, fim);
    end
    req = '0;
    cyc();
  endtask

  task automatic test_reset_mid();
    bit ok;
    atraso[0 +: CW] = 16'd5;
    tap_sel = 3'd3;
    req     = 4'b0001;
    cyc();
    repeat (3) cyc();
    #2 rstf_n = 1'b0;
    #1;
    tests++;
    if (gnt !== 4'b0000 || ocupado !== 1'b0 || fim !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_async: gnt=%b ocupado=%b fim=%b, required 0000 0 0000", gnt, ocupado,
               fim);
    end
    req = '0;
    @(negedge clkf);
    rstf_n = 1'b1;
    ok = 1;
    repeat (5) begin
      cyc();
      if (fim !== 4'b0000 || gnt !== 4'b0000) ok = 0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_mid_after: gnt=%b fim=%b, required 0000 0000", gnt, fim);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] eg, ef;
    logic et;
    rstf_n = 1'b0;
    req    = '0;
    cyc();
    rstf_n  = 1'b1;
    m_phase = 0;
    m_rr    = 0;
    m_idx   = 0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(11) == 0) req[b] = ~req[b];
        atraso[b*CW +: CW] = 16'($urandom_range(3));
      end
      tap_sel = 3'($urandom_range(2));
      @(posedge clkf);
      model_edge(req, atraso, tap_sel);
      #1;
      eg = (m_phase == 1) ? (4'b0001 << m_idx) : 4'b0000;
      ef = (m_phase == 2) ? (4'b0001 << m_idx) : 4'b0000;
      et = (m_phase == 1) && ((m_el % m_p) == m_p - 1);
      tests++;
      if (gnt !== eg) begin
        fails++;
        $display("FAIL rand_gnt c%0d: gnt=%b, required %b", c, gnt, eg);
      end
      tests++;
      if (fim !== ef) begin
        fails++;
        $display("FAIL rand_fim c%0d: fim=%b, required %b", c, fim, ef);
      end
      tests++;
      if (ocupado !== (m_phase != 0)) begin
        fails++;
        $display("FAIL rand_ocupado c%0d: ocupado=%b, required %b", c, ocupado, m_phase != 0);
      end
      tests++;
      if (tick !== et) begin
        fails++;
        $display("FAIL rand_tick c%0d: tick=%b, required %b", c, tick, et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_cancel();
    test_zero_delay();
    test_clamp();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
